// File: rtl/lane_lock_ctrl.sv
// lane_lock_ctrl: per-lane bring-up sequencer for a bank of 64B/67B decoders.
// Each lane pulses its decoder reset, waits for word lock, qualifies that lock
// for a run of consecutive cycles and then declares the lane up. Lock timeouts
// and lock loss both re-sync the lane; only timeouts are counted as retries.
//
// Per-lane handshake with the decoder: LANE_RESET high holds the decoder in
// reset; LANE_LOCKED is sampled only while LANE_RESET is low and is assumed
// to be synchronous to USER_CLK. LANE_STATE exposes every lane FSM for
// observation (DISABLED=0, RESET=1, WAIT_LOCK=2, QUALIFY=3, UP=4).
module lane_lock_ctrl #(
   parameter int NUM_LANES     = 4,
   parameter int RESET_CYCLES  = 8,
   parameter int LOCK_TIMEOUT  = 4096,
   parameter int STABLE_CYCLES = 256
) (
   input  logic                     USER_CLK,
   input  logic                     SYSTEM_RESET,
   input  logic                     ENABLE,
   input  logic                     CLEAR_COUNTS,
   input  logic [NUM_LANES-1:0]     LANE_LOCKED,
   output logic [NUM_LANES-1:0]     LANE_RESET,
   output logic [NUM_LANES-1:0]     LANE_UP,
   output logic                     ALL_LANES_UP,
   output logic [NUM_LANES-1:0]     LOSS_EVENT,
   output logic [8*NUM_LANES-1:0]   RETRY_COUNT,
   output logic [3*NUM_LANES-1:0]   LANE_STATE
);

   // One timer per lane, sized for the longest of the three phases.
   localparam int MAX_AB  = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_CYC = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
   localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [TW-1:0] RESET_LAST   = TW'(RESET_CYCLES - 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
   localparam logic [TW-1:0] STABLE_LAST  = TW'(STABLE_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_DISABLED  = 3'd0,
      ST_RESET     = 3'd1,
      ST_WAIT_LOCK = 3'd2,
      ST_QUALIFY   = 3'd3,
      ST_UP        = 3'd4
   } lane_state_t;

   logic [NUM_LANES-1:0] up_vec;

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      lane_state_t   state;
      logic [TW-1:0] timer;
      logic [7:0]    retry;
      logic          loss;

      // Lane FSM with its timer, retry counter and loss pulse; ENABLE low wins over everything.
      always_ff @(posedge USER_CLK or posedge SYSTEM_RESET) begin
         if (SYSTEM_RESET) begin
            state <= ST_DISABLED;
            timer <= '0;
            retry <= '0;
            loss  <= 1'b0;
         end else begin
            loss <= 1'b0;
            if (CLEAR_COUNTS) begin
               retry <= '0;
            end
            if (!ENABLE) begin
               state <= ST_DISABLED;
               timer <= '0;
            end else begin
               case (state)
                  ST_DISABLED: begin
                     state <= ST_RESET;
                     timer <= '0;
                  end
                  ST_RESET: begin
                     if (timer == RESET_LAST) begin
                        state <= ST_WAIT_LOCK;
                        timer <= '0;
                     end else begin
                        timer <= timer + TW'(1);
                     end
                  end
                  ST_WAIT_LOCK: begin
                     if (LANE_LOCKED[i]) begin
                        state <= ST_QUALIFY;
                        timer <= '0;
                     end else if (timer == TIMEOUT_LAST) begin
                        state <= ST_RESET;
                        timer <= '0;
                        // A simultaneous clear takes precedence over the increment.
                        if (!CLEAR_COUNTS && (retry != 8'hFF)) begin
                           retry <= retry + 8'd1;
                        end
                     end else begin
                        timer <= timer + TW'(1);
                     end
                  end
                  ST_QUALIFY: begin
                     if (!LANE_LOCKED[i]) begin
                        state <= ST_WAIT_LOCK;
                        timer <= '0;
                     end else if (timer == STABLE_LAST) begin
                        state <= ST_UP;
                        timer <= '0;
                     end else begin
                        timer <= timer + TW'(1);
                     end
                  end
                  ST_UP: begin
                     if (!LANE_LOCKED[i]) begin
                        state <= ST_RESET;
                        timer <= '0;
                        loss  <= 1'b1;
                     end
                  end
                  default: begin
                     state <= ST_DISABLED;
                     timer <= '0;
                  end
               endcase
            end
         end
      end

      assign LANE_RESET[i]          = (state == ST_DISABLED) || (state == ST_RESET);
      assign up_vec[i]              = (state == ST_UP);
      assign LOSS_EVENT[i]          = loss;
      assign RETRY_COUNT[8*i +: 8]  = retry;
      assign LANE_STATE[3*i +: 3]   = state;
   end

   assign LANE_UP = up_vec;

   // Aggregate link-up, registered one cycle behind the per-lane up flags.
   always_ff @(posedge USER_CLK or posedge SYSTEM_RESET) begin
      if (SYSTEM_RESET) begin
         ALL_LANES_UP <= 1'b0;
      end else begin
         ALL_LANES_UP <= &up_vec;
      end
   end

endmodule

// File: doc/lane_lock_ctrl.md
Name: lane_lock_ctrl

Overview:
- Per-lane sequencer for a bank of 64B/67B decoders.
- Drives each decoder's reset, waits for word lock, and qualifies lock stability before declaring the lane up.
- Re-syncs a lane on lock timeout or lock loss, counts retries, and reports aggregate link-up to the framing layer.
- Sits between the lane decoders and the Interlaken RX protocol logic.

Parameters:
- NUM_LANES, 4: number of decoder lanes controlled.
- RESET_CYCLES, 8: cycles LANE_RESET is held per resync attempt; must be >= 1.
- LOCK_TIMEOUT, 4096: cycles allowed in WAIT_LOCK before retry; must be >= 2.
- STABLE_CYCLES, 256: consecutive locked cycles needed before a lane is declared up; must be >= 1.

Ports:
- USER_CLK  in  1  single clock.
- SYSTEM_RESET  in  1  asynchronous, active-high reset.
- ENABLE  in  1  global enable; low forces all lanes to DISABLED.
- CLEAR_COUNTS  in  1  synchronous clear of all RETRY_COUNT fields.
- LANE_LOCKED  in  NUM_LANES  per-lane LOCKED from the decoders.
- LANE_RESET  out  NUM_LANES  per-lane decoder reset.
- LANE_UP  out  NUM_LANES  lane qualified and up.
- ALL_LANES_UP  out  1  every lane up.
- LOSS_EVENT  out  NUM_LANES  one-cycle pulse when an up lane loses lock.
- RETRY_COUNT  out  8*NUM_LANES  per-lane saturating timeout-retry count; lane i occupies [8i+7:8i].
- LANE_STATE  out  3*NUM_LANES  per-lane state encoding.

Behaviour:
- Reset (async assert; release sampled on USER_CLK):
  - all lanes DISABLED
  - LANE_RESET all 1, LANE_UP 0, ALL_LANES_UP 0, LOSS_EVENT 0
  - RETRY_COUNT 0, timers 0
- Lanes are independent identical FSMs. Each has one timer, wide enough for max(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) - 1. The timer is zeroed on every state change.
- Outputs are all registered. LANE_RESET and LANE_UP are decoded from the state register, so they are valid in the same cycle the state is entered.
- State encoding: DISABLED=0, RESET=1, WAIT_LOCK=2, QUALIFY=3, UP=4.
- DISABLED (LANE_RESET=1):
  - ENABLE=1 -> RESET.
- RESET (LANE_RESET=1):
  - timer increments each cycle; at timer==RESET_CYCLES-1 -> WAIT_LOCK.
  - LANE_LOCKED is ignored.
  - LANE_RESET therefore stays high for exactly RESET_CYCLES cycles.
- WAIT_LOCK (LANE_RESET=0):
  - LANE_LOCKED=1 -> QUALIFY.
  - else at timer==LOCK_TIMEOUT-1 -> RESET and RETRY_COUNT+1 (saturates at 255).
- QUALIFY (LANE_RESET=0):
  - LANE_LOCKED=0 -> WAIT_LOCK (no retry increment; timeout window restarts).
  - else at timer==STABLE_CYCLES-1 -> UP.
  - UP is therefore reached after STABLE_CYCLES consecutive locked samples.
- UP (LANE_UP=1):
  - LANE_LOCKED=0 -> RESET; LOSS_EVENT pulses for 1 cycle, coincident with the first RESET cycle.
  - RETRY_COUNT is not incremented on lock loss.
- ENABLE=0 forces the next state DISABLED from any state. This has highest priority, and no LOSS_EVENT is generated.
- ALL_LANES_UP is registered: high in the cycle after all LANE_UP bits are 1, low in the cycle after any bit is 0.
- CLEAR_COUNTS=1 zeroes all RETRY_COUNT fields next cycle. If it coincides with an increment, the clear wins.
- Reset asserted mid-operation: immediate return to reset values, regardless of state or timer.
- LANE_LOCKED is assumed synchronous to USER_CLK; no synchroniser is included.

Test Plan:
Bench parameters: NUM_LANES=4, RESET_CYCLES=4, LOCK_TIMEOUT=16, STABLE_CYCLES=8.
- Bring-up: release reset with ENABLE=1, and raise LANE_LOCKED=4'hF when LANE_RESET falls -> LANE_RESET high exactly 4 cycles; LANE_UP=4'hF 8 cycles after LANE_LOCKED rises; ALL_LANES_UP 1 cycle later; RETRY_COUNT all 0.
- Timeout: lane 2 never locks -> LANE_RESET[2] re-asserts every 20 cycles (4 reset + 16 wait); RETRY_COUNT[23:16] increments per attempt and saturates at 255 after 255 attempts; CLEAR_COUNTS pulse -> 0 next cycle; ALL_LANES_UP stays 0.
- Qualify glitch: lane 0 locked for 5 cycles, low 1 cycle, then locked -> returns to WAIT_LOCK with no retry; LANE_UP[0] rises only after 8 further consecutive locked cycles.
- Lock loss: all lanes up, drop LANE_LOCKED[1] for 1 cycle -> LOSS_EVENT[1] single pulse; LANE_RESET[1] high 4 cycles; ALL_LANES_UP falls the cycle after LANE_UP[1]; RETRY_COUNT[15:8] unchanged.
- Disable mid-qualify plus async reset: ENABLE=0 during QUALIFY -> LANE_STATE=0 and LANE_RESET=1 next cycle, no LOSS_EVENT. Assert SYSTEM_RESET between clock edges while lanes are UP -> outputs return to reset values immediately, without waiting for a clock edge.
- Simultaneous events: CLEAR_COUNTS in the same cycle as a lane-3 timeout -> RETRY_COUNT[31:24]=0.
